m3_phase_drive: RTL and testbench



---
 rtl/m3_phase_drive.sv | 139 +++++++++++++
 tb/tb_m3_phase_drive.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/m3_phase_drive.sv
// Six-gate U/V/W half-bridge driver: PWM-chopped high sides, dead-time interlocked turn-on, shadowed power level.
// Gates lag stepI by two cycles and no handshake is used; optional M3_BRAKE_EN makes forceStopI brake on all low sides.
module m3_phase_drive #(
  parameter int PWM_BITS    = 8,
  parameter int DEAD_CYCLES = 4,
  parameter int POWER_INIT  = 32,
  parameter int POWER_STEP  = 4,
  parameter int POWER_MAX   = 240
) (
  input  logic                clkI,
  input  logic                nRstI,
  input  logic [3:0]          stepI,
  input  logic                workingI,
  input  logic                invRotateI,
  input  logic                forceStopI,
  input  logic                powerINCi,
  input  logic                powerDECi,
  output logic [5:0]          gateO,
  output logic [PWM_BITS-1:0] powerO,
  output logic                pwmSyncO
);

  localparam logic [3:0]          DEAD   = 4'(DEAD_CYCLES);
  localparam logic [PWM_BITS-1:0] INIT_V = PWM_BITS'(POWER_INIT);
  localparam logic [PWM_BITS-1:0] STEP_N = PWM_BITS'(POWER_STEP);
  localparam logic [PWM_BITS:0]   STEP_W = (PWM_BITS+1)'(POWER_STEP);
  localparam logic [PWM_BITS:0]   MAX_W  = (PWM_BITS+1)'(POWER_MAX);

  // Phase index: 2 = U, 1 = V, 0 = W
  logic [2:0]       req_h_d, req_h_q, req_l_d, req_l_q;
  logic [2:0]       gate_h_d, gate_h_q, gate_l_d, gate_l_q;
  logic [2:0][3:0]  off_h_d, off_h_q, off_l_d, off_l_q;
  logic [PWM_BITS-1:0] pwm_cnt_d, pwm_cnt_q;
  logic [PWM_BITS-1:0] power_reg_d, power_reg_q;
  logic [PWM_BITS-1:0] power_d, power_q;
  logic                sync_d, sync_q;
  logic [2:0]          sector;
  logic                active;
  logic                pwm_on;
  logic                wrap;
  logic [PWM_BITS:0]   sum;

  always_comb begin
    req_h_d = 3'b000;
    req_l_d = 3'b000;
    sector  = stepI[3:1];
    if (invRotateI) begin
      sector = 3'd5 - stepI[3:1];
    end
    active = workingI && !forceStopI && (stepI < 4'd12);
    if (active) begin
      case (sector)
        3'd0:    begin req_h_d = 3'b100; req_l_d = 3'b010; end
        3'd1:    begin req_h_d = 3'b100; req_l_d = 3'b001; end
        3'd2:    begin req_h_d = 3'b010; req_l_d = 3'b001; end
        3'd3:    begin req_h_d = 3'b010; req_l_d = 3'b100; end
        3'd4:    begin req_h_d = 3'b001; req_l_d = 3'b100; end
        3'd5:    begin req_h_d = 3'b001; req_l_d = 3'b010; end
        default: begin req_h_d = 3'b000; req_l_d = 3'b000; end
      endcase
    end
`ifdef M3_BRAKE_EN
    if (forceStopI) begin
      req_h_d = 3'b000;
      req_l_d = 3'b111;
    end
`endif
  end

  assign pwm_on = (pwm_cnt_q < power_q);
  assign wrap   = &pwm_cnt_q;

  // Off counters follow the gate value being loaded, so a count of DEAD
  // means the switch has been off for DEAD full cycles.
  always_comb begin
    gate_h_d = 3'b000;
    gate_l_d = 3'b000;
    off_h_d  = off_h_q;
    off_l_d  = off_l_q;
    for (int i = 0; i < 3; i++) begin
      gate_h_d[i] = req_h_q[i] & pwm_on & (off_l_q[i] >= DEAD);
      gate_l_d[i] = req_l_q[i] & (off_h_q[i] >= DEAD);
      if (gate_h_d[i]) begin
        off_h_d[i] = 4'd0;
      end else if (off_h_q[i] != 4'd15) begin
        off_h_d[i] = off_h_q[i] + 4'd1;
      end
      if (gate_l_d[i]) begin
        off_l_d[i] = 4'd0;
      end else if (off_l_q[i] != 4'd15) begin
        off_l_d[i] = off_l_q[i] + 4'd1;
      end
    end
  end

  always_comb begin
    pwm_cnt_d   = pwm_cnt_q + PWM_BITS'(1);
    sync_d      = wrap;
    power_d     = wrap ? power_reg_q : power_q;
    power_reg_d = power_reg_q;
    sum         = {1'b0, power_reg_q} + STEP_W;
    if (powerINCi && !powerDECi) begin
      power_reg_d = (sum > MAX_W) ? MAX_W[PWM_BITS-1:0] : sum[PWM_BITS-1:0];
    end else if (powerDECi && !powerINCi) begin
      power_reg_d = (power_reg_q < STEP_N) ? '0 : power_reg_q - STEP_N;
    end
  end

  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      req_h_q     <= 3'b000;
      req_l_q     <= 3'b000;
      gate_h_q    <= 3'b000;
      gate_l_q    <= 3'b000;
      off_h_q     <= '1;
      off_l_q     <= '1;
      pwm_cnt_q   <= '0;
      power_reg_q <= INIT_V;
      power_q     <= INIT_V;
      sync_q      <= 1'b0;
    end else begin
      req_h_q     <= req_h_d;
      req_l_q     <= req_l_d;
      gate_h_q    <= gate_h_d;
      gate_l_q    <= gate_l_d;
      off_h_q     <= off_h_d;
      off_l_q     <= off_l_d;
      pwm_cnt_q   <= pwm_cnt_d;
      power_reg_q <= power_reg_d;
      power_q     <= power_d;
      sync_q      <= sync_d;
    end
  end

  assign gateO    = {gate_h_q[2], gate_l_q[2], gate_h_q[1], gate_l_q[1], gate_h_q[0], gate_l_q[0]};
  assign powerO   = power_q;
  assign pwmSyncO = sync_q;

endmodule

// File: tb/tb_m3_phase_drive.sv
// Scoreboard bench for m3_phase_drive: stimulus queues expected gate/power values per cycle, a negedge monitor checks them.
module tb_m3_phase_drive;
  logic       clkI = 1'b0;
  logic       nRstI = 1'b0;
  logic [3:0] stepI;
  logic       workingI, invRotateI, forceStopI, powerINCi, powerDECi;
  logic [5:0] gateO;
  logic [7:0] powerO;
  logic       pwmSyncO;

  m3_phase_drive dut (
    .clkI(clkI), .nRstI(nRstI), .stepI(stepI), .workingI(workingI),
    .invRotateI(invRotateI), .forceStopI(forceStopI), .powerINCi(powerINCi),
    .powerDECi(powerDECi), .gateO(gateO), .powerO(powerO), .pwmSyncO(pwmSyncO)
  );

  always #5 clkI = ~clkI;

  int cyc = 0;
  always @(posedge clkI or negedge nRstI) begin
    if (!nRstI) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    int         at;
    logic       gchk;
    logic [5:0] gate;
    logic       pchk;
    logic [7:0] pow;
    logic       schk;
    logic       sync;
    string      name;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  logic [7:0] prev_pow;

  task automatic push(int at, logic gchk, logic [5:0] g, logic pchk, logic [7:0] p,
                      logic schk, logic s, string nm);
    exp_t e;
    e.at = at; e.gchk = gchk; e.gate = g; e.pchk = pchk; e.pow = p;
    e.schk = schk; e.sync = s; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic exp_g(int at, logic [5:0] g, string nm);
    push(at, 1'b1, g, 1'b0, 8'd0, 1'b0, 1'b0, nm);
  endtask

  // Power load is always expected together with the sync pulse
  task automatic exp_p(int at, logic [7:0] p, string nm);
    push(at, 1'b0, 6'd0, 1'b1, p, 1'b1, 1'b1, nm);
  endtask

  task automatic wait_to(int n);
    if (cyc > n) begin
      errors++;
      $display("FAIL schedule: at cycle %0d, wanted cycle %0d", cyc, n);
    end
    while (cyc < n) begin
      @(posedge clkI);
      #1;
    end
  endtask

  always @(negedge clkI) begin
    if (nRstI) begin
      int mi;
      mi = 0;
      while (mi < sb.size()) begin
        if (sb[mi].at == cyc) begin
          if (sb[mi].gchk) begin
            checks++;
            if (gateO !== sb[mi].gate) begin
              errors++;
              $display("FAIL %s: cyc %0d gateO=%b expected %b", sb[mi].name, cyc, gateO, sb[mi].gate);
            end
          end
          if (sb[mi].pchk) begin
            checks++;
            if (powerO !== sb[mi].pow) begin
              errors++;
              $display("FAIL %s: cyc %0d powerO=%0d expected %0d", sb[mi].name, cyc, powerO, sb[mi].pow);
            end
          end
          if (sb[mi].schk) begin
            checks++;
            if (pwmSyncO !== sb[mi].sync) begin
              errors++;
              $display("FAIL %s: cyc %0d pwmSyncO=%b expected %b", sb[mi].name, cyc, pwmSyncO, sb[mi].sync);
            end
          end
          sb.delete(mi);
        end else begin
          mi++;
        end
      end
      checks++;
      if ((gateO[5] & gateO[4]) | (gateO[3] & gateO[2]) | (gateO[1] & gateO[0])) begin
        errors++;
        $display("FAIL shoot_through: cyc %0d gateO=%b expected no H+L pair", cyc, gateO);
      end
      checks++;
      if (powerO !== prev_pow && pwmSyncO !== 1'b1) begin
        errors++;
        $display("FAIL power_shadow: cyc %0d powerO %0d->%0d expected change only with pwmSyncO", cyc, prev_pow, powerO);
      end
    end
    prev_pow = powerO;
  end

  initial begin
    stepI = 4'd0; workingI = 1'b1; invRotateI = 1'b0; forceStopI = 1'b0;
    powerINCi = 1'b0; powerDECi = 1'b0;
    repeat (3) @(posedge clkI);
    #1 nRstI = 1'b1;

    push(0, 1'b1, 6'b000000, 1'b1, 8'd32, 1'b1, 1'b0, "reset_state");
    exp_g(1,   6'b000000, "pipe_fill");
    exp_g(2,   6'b100100, "s0_on_first");
    exp_g(32,  6'b100100, "s0_on_last");
    exp_g(33,  6'b000100, "s0_off");
    exp_g(100, 6'b000100, "s0_off_mid");
    exp_p(256, 8'd32,     "wrap1");
    exp_g(257, 6'b100100, "s0_on_2nd");

    wait_to(257); stepI = 4'd6;
    exp_g(259, 6'b000000, "s0to3_off");
    exp_g(262, 6'b000000, "s0to3_dead");
    exp_g(263, 6'b011000, "s0to3_on");
    exp_g(288, 6'b011000, "s3_on_last");
    exp_g(289, 6'b010000, "s3_off");

    wait_to(300); invRotateI = 1'b1; stepI = 4'd0;
    exp_g(302, 6'b000100, "inv_vL");
    exp_p(512, 8'd32,     "wrap2");
    exp_g(513, 6'b000110, "inv_wH_on");
    exp_g(544, 6'b000110, "inv_wH_last");
    exp_g(545, 6'b000100, "inv_wH_off");

    wait_to(600); powerINCi = 1'b1;
    wait_to(660); powerINCi = 1'b0;
    exp_p(768,  8'd240,    "inc_sat");
    exp_g(1008, 6'b000110, "duty240_last");
    exp_g(1009, 6'b000100, "duty240_off");
    exp_p(1024, 8'd240,    "wrap_240");

    wait_to(1100); powerDECi = 1'b1;
    wait_to(1170); powerDECi = 1'b0;
    exp_p(1280, 8'd0,      "dec_floor");
    exp_g(1281, 6'b000100, "duty0_a");
    exp_g(1282, 6'b000100, "duty0_b");

    wait_to(1300); powerINCi = 1'b1;
    wait_to(1301); powerDECi = 1'b1;
    wait_to(1302); powerINCi = 1'b0; powerDECi = 1'b0;
    exp_p(1536, 8'd4,      "inc_dec_same");
    exp_g(1540, 6'b000110, "duty4_last");
    exp_g(1541, 6'b000100, "duty4_off");

    wait_to(1600); invRotateI = 1'b0; stepI = 4'd2;
    exp_g(1602, 6'b000001, "s1_wL");
    exp_g(1793, 6'b100001, "s1_uH");

    wait_to(1793); forceStopI = 1'b1;
    exp_g(1794, 6'b100001, "stop_pipe");
`ifdef M3_BRAKE_EN
    exp_g(1795, 6'b000101, "brake_hi_off");
    exp_g(1798, 6'b000101, "brake_dead");
    exp_g(1799, 6'b010101, "brake_all_low");
`else
    exp_g(1795, 6'b000000, "stop_off");
    exp_g(1799, 6'b000000, "stop_hold");
`endif
    wait_to(1850); forceStopI = 1'b0;
    exp_g(1852, 6'b000001, "stop_release");

    wait_to(1900); stepI = 4'd15;
    exp_g(1902, 6'b000000, "idle15");
    wait_to(1920); stepI = 4'd2;
    exp_g(1922, 6'b000001, "resume1");
    wait_to(1950); stepI = 4'd12;
    exp_g(1952, 6'b000000, "idle12");
    wait_to(1970); stepI = 4'd2;
    exp_g(1972, 6'b000001, "resume2");
    wait_to(2000); workingI = 1'b0;
    exp_g(2002, 6'b000000, "not_working");
    wait_to(2020); workingI = 1'b1;
    exp_g(2022, 6'b000001, "resume3");
    exp_g(2050, 6'b100001, "mid_pwm_on");

    wait_to(2050);
    @(negedge clkI);
    #2 nRstI = 1'b0;
    #1;
    checks++;
    if (gateO !== 6'b000000) begin
      errors++;
      $display("FAIL async_reset_gate: gateO=%b expected 000000", gateO);
    end
    checks++;
    if (powerO !== 8'd32) begin
      errors++;
      $display("FAIL async_reset_power: powerO=%0d expected 32", powerO);
    end
    checks++;
    if (pwmSyncO !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_sync: pwmSyncO=%b expected 0", pwmSyncO);
    end

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL unchecked: %0d expectations left, first %s at cyc %0d, expected 0 left",
               sb.size(), sb[0].name, sb[0].at);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
